// File: rtl/alu_accum_seq_pkg.sv
// Shared opcode encodings and FSM state type for the accumulator ALU.
// The sequential multiplier is the only operation that spans more than one cycle.
package alu_accum_pkg;

  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [FUNC_W-1:0] OP_MUL  = 3'b001;
  localparam logic [FUNC_W-1:0] OP_SHL  = 3'b010;
  localparam logic [FUNC_W-1:0] OP_HOLD = 3'b011;
  localparam logic [FUNC_W-1:0] OP_SUB  = 3'b100;
  localparam logic [FUNC_W-1:0] OP_AND  = 3'b101;
  localparam logic [FUNC_W-1:0] OP_OR   = 3'b110;
  localparam logic [FUNC_W-1:0] OP_SHR  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_accum_seq_if.sv
// Request/result bundle between the input stage and the accumulator ALU.
// The master drives the operation request; the slave (the ALU) returns status and the accumulator.
interface alu_accum_seq_if
  import alu_accum_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) ();

  logic              In_valid;
  logic              In_ready;
  logic [FUNC_W-1:0] Function;
  logic [DATA_W-1:0] Data;
  logic [ACC_W-1:0]  ALUout;
  logic              Ovf;
  logic              Busy;
  logic              Done;

  modport master (
    output In_valid, Function, Data,
    input  In_ready, ALUout, Ovf, Busy, Done
  );

  modport slave (
    input  In_valid, Function, Data,
    output In_ready, ALUout, Ovf, Busy, Done
  );

endinterface

// File: rtl/alu_accum_seq_mult.sv
// Radix-2 shift-add multiplier: one partial product per cycle, DATA_W cycles per product.
// The product is presented combinationally during the last step so the caller can capture it on that edge.
module seq_mult #(
  parameter int DATA_W = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int PROD_W = 2 * DATA_W;

  logic              busy_q,   busy_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PROD_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q,    acc_d;
  logic [PROD_W-1:0] partial;
  logic [PROD_W-1:0] sum;
  logic              lastStep;

  // Multiplier bits are consumed LSB first while the multiplicand shifts left.
  always_comb begin
    partial  = mplier_q[0] ? mcand_q : '0;
    sum      = acc_q + partial;
    lastStep = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = PROD_W'(a);
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (lastStep) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = busy_q;
  assign done    = lastStep;
  assign product = sum;

endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator ALU with valid/ready intake, eight functions, overflow flag and a multi-cycle multiply.
// Reset_b is an active-high synchronous reset despite its name.
module alu_accum_seq
  import alu_accum_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic           Clock,
  input  logic           Reset_b,
  alu_accum_seq_if.slave bus
);

  generate
    if (ACC_W < 2 * DATA_W) begin : g_width_check
      $error("alu_accum_seq: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q,   acc_d;
  logic                 ovf_q,   ovf_d;
  logic                 done_q,  done_d;

  logic                 accept;
  logic                 mulStart;
  logic                 multBusy;
  logic                 multDone;
  logic [2*DATA_W-1:0]  multProduct;

  logic [ACC_W-1:0]     dExt;
  logic [ACC_W:0]       aluSum;
  logic [2*ACC_W-1:0]   shlWide;
  logic [2*ACC_W-1:0]   shrWide;
  logic                 shiftAll;
  logic [ACC_W-1:0]     aluResult;
  logic                 aluOvf;

  assign accept   = bus.In_valid && (state_q == S_IDLE);
  assign mulStart = accept && (bus.Function == OP_MUL);

  seq_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .start   (mulStart),
    .a       (acc_q[DATA_W-1:0]),
    .b       (bus.Data),
    .busy    (multBusy),
    .done    (multDone),
    .product (multProduct)
  );

  // Shifts run in a double-width window so the bits pushed out land in the other half.
  always_comb begin
    dExt     = ACC_W'(bus.Data);
    aluSum   = {1'b0, acc_q} + {1'b0, dExt};
    shlWide  = {{ACC_W{1'b0}}, acc_q} << bus.Data;
    shrWide  = {acc_q, {ACC_W{1'b0}}} >> bus.Data;
    shiftAll = (32'(bus.Data) >= 32'(ACC_W));

    aluResult = acc_q;
    aluOvf    = ovf_q;

    case (bus.Function)
      OP_ADD: begin
        aluResult = aluSum[ACC_W-1:0];
        aluOvf    = aluSum[ACC_W];
      end
      OP_SHL: begin
        aluResult = shiftAll ? '0 : shlWide[ACC_W-1:0];
        aluOvf    = shiftAll ? (|acc_q) : (|shlWide[2*ACC_W-1:ACC_W]);
      end
      OP_SUB: begin
        aluResult = acc_q - dExt;
        aluOvf    = (acc_q < dExt);
      end
      OP_AND: begin
        aluResult = acc_q & dExt;
        aluOvf    = 1'b0;
      end
      OP_OR: begin
        aluResult = acc_q | dExt;
        aluOvf    = 1'b0;
      end
      OP_SHR: begin
        aluResult = shiftAll ? '0 : shrWide[2*ACC_W-1:ACC_W];
        aluOvf    = shiftAll ? (|acc_q) : (|shrWide[ACC_W-1:0]);
      end
      default: begin
        aluResult = acc_q;
        aluOvf    = ovf_q;
      end
    endcase
  end

  // MUL leaves the accumulator untouched until the multiplier signals its final step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.Function == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            acc_d  = aluResult;
            ovf_d  = aluOvf;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (multDone) begin
          acc_d   = ACC_W'(multProduct);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.In_ready = (state_q == S_IDLE);
  assign bus.Busy     = multBusy;
  assign bus.ALUout   = acc_q;
  assign bus.Ovf      = ovf_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq: a vector table plus hand-built multiply/reset sequences,
// with every expected result queued at acceptance and compared when Done pulses.
module tb_alu_accum_seq;
  import alu_accum_pkg::*;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 8;

  typedef struct {
    logic [ACC_W-1:0] alu;
    logic             ovf;
  } result_t;

  typedef struct {
    logic [2:0]        func;
    logic [DATA_W-1:0] data;
    logic [ACC_W-1:0]  expAlu;
    logic              expOvf;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset_b;

  alu_accum_seq_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  alu_accum_seq #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  result_t          expQ[$];
  int               totalChecks = 0;
  int               badChecks   = 0;
  logic [ACC_W-1:0] modelAcc;
  logic             modelOvf;
  vec_t             vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour written bit-serially so it shares no structure with the design.
  task automatic refModel(input logic [2:0] f, input logic [DATA_W-1:0] d,
                          inout logic [ACC_W-1:0] acc, inout logic ovf);
    int s;
    case (f)
      OP_ADD: begin
        s   = int'(acc) + int'(d);
        ovf = (s > 255);
        acc = s[7:0];
      end
      OP_MUL: begin
        s   = int'(acc[3:0]) * int'(d);
        acc = s[7:0];
        ovf = 1'b0;
      end
      OP_SHL: begin
        ovf = 1'b0;
        for (int i = 0; i < int'(d); i++) begin
          if (acc[7]) ovf = 1'b1;
          acc = {acc[6:0], 1'b0};
        end
      end
      OP_SUB: begin
        s   = int'(acc) - int'(d);
        ovf = (s < 0);
        acc = s[7:0];
      end
      OP_AND: begin
        acc = acc & {4'h0, d};
        ovf = 1'b0;
      end
      OP_OR: begin
        acc = acc | {4'h0, d};
        ovf = 1'b0;
      end
      OP_SHR: begin
        ovf = 1'b0;
        for (int i = 0; i < int'(d); i++) begin
          if (acc[0]) ovf = 1'b1;
          acc = {1'b0, acc[7:1]};
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [DATA_W-1:0] d,
                               input logic [ACC_W-1:0] expAlu, input logic expOvf);
    int waitCycles = 0;
    result_t r;
    @(negedge Clock);
    while (bus.In_ready !== 1'b1 && waitCycles < 40) begin
      @(negedge Clock);
      waitCycles++;
    end
    if (bus.In_ready !== 1'b1) begin
      checkOutput("In_ready timeout", 32'(bus.In_ready), 32'd1);
      return;
    end
    bus.In_valid = 1'b1;
    bus.Function = f;
    bus.Data     = d;
    @(posedge Clock);
    r.alu = expAlu;
    r.ovf = expOvf;
    expQ.push_back(r);
    modelAcc = expAlu;
    modelOvf = expOvf;
    #1 bus.In_valid = 1'b0;
  endtask

  task automatic modelStimulus(input logic [2:0] f, input logic [DATA_W-1:0] d);
    logic [ACC_W-1:0] a;
    logic             o;
    a = modelAcc;
    o = modelOvf;
    refModel(f, d, a, o);
    applyStimulus(f, d, a, o);
  endtask

  task automatic resetDut(input bit flush);
    int n = 0;
    if (!flush) begin
      while (expQ.size() != 0 && n < 60) begin
        @(negedge Clock);
        n++;
      end
      checkOutput("drain before reset", 32'(expQ.size()), 32'd0);
    end
    @(negedge Clock);
    Reset_b      = 1'b1;
    bus.In_valid = 1'b0;
    if (flush) expQ.delete();
    @(negedge Clock);
    Reset_b  = 1'b0;
    modelAcc = '0;
    modelOvf = 1'b0;
    checkOutput("reset ALUout",   32'(bus.ALUout),   32'd0);
    checkOutput("reset Ovf",      32'(bus.Ovf),      32'd0);
    checkOutput("reset Busy",     32'(bus.Busy),     32'd0);
    checkOutput("reset In_ready", 32'(bus.In_ready), 32'd1);
    checkOutput("reset Done",     32'(bus.Done),     32'd0);
  endtask

  task automatic loadAcc(input logic [ACC_W-1:0] v);
    resetDut(1'b0);
    applyStimulus(OP_OR,  v[7:4], {4'h0, v[7:4]}, 1'b0);
    applyStimulus(OP_SHL, 4'd4,   {v[7:4], 4'h0}, 1'b0);
    applyStimulus(OP_OR,  v[3:0], v,              1'b0);
  endtask

  // Scoreboard side: every Done pulse must consume exactly one queued result.
  always @(negedge Clock) begin
    result_t e;
    if (bus.Done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("Done with nothing pending", 32'(bus.Done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result ALUout", 32'(bus.ALUout), 32'(e.alu));
        checkOutput("result Ovf",    32'(bus.Ovf),    32'(e.ovf));
      end
    end
  end

  initial begin
    int n;
    Reset_b      = 1'b0;
    bus.In_valid = 1'b0;
    bus.Function = OP_ADD;
    bus.Data     = '0;

    vecs[0]  = '{OP_ADD,  4'h5, 8'h05, 1'b0};
    vecs[1]  = '{OP_ADD,  4'hF, 8'h14, 1'b0};
    vecs[2]  = '{OP_ADD,  4'hF, 8'h23, 1'b0};
    vecs[3]  = '{OP_SUB,  4'h2, 8'h21, 1'b0};
    vecs[4]  = '{OP_AND,  4'h7, 8'h01, 1'b0};
    vecs[5]  = '{OP_SUB,  4'h2, 8'hFF, 1'b1};
    vecs[6]  = '{OP_OR,   4'h0, 8'hFF, 1'b0};
    vecs[7]  = '{OP_SHR,  4'h4, 8'h0F, 1'b1};
    vecs[8]  = '{OP_MUL,  4'hF, 8'hE1, 1'b0};
    vecs[9]  = '{OP_SHR,  4'h7, 8'h01, 1'b1};
    vecs[10] = '{OP_HOLD, 4'h9, 8'h01, 1'b1};
    vecs[11] = '{OP_SHL,  4'h7, 8'h80, 1'b0};
    vecs[12] = '{OP_SHR,  4'h7, 8'h01, 1'b0};
    vecs[13] = '{OP_ADD,  4'h0, 8'h01, 1'b0};
    vecs[14] = '{OP_SHL,  4'h3, 8'h08, 1'b0};
    vecs[15] = '{OP_SHR,  4'h8, 8'h00, 1'b1};
    vecs[16] = '{OP_SHL,  4'hF, 8'h00, 1'b0};

    resetDut(1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].func, vecs[i].data, vecs[i].expAlu, vecs[i].expOvf);
    end

    // Add carry-out and subtract borrow around the wrap point.
    loadAcc(8'hFE);
    applyStimulus(OP_ADD, 4'h3, 8'h01, 1'b1);
    applyStimulus(OP_SUB, 4'h2, 8'hFF, 1'b1);

    loadAcc(8'h81);
    applyStimulus(OP_SHL, 4'h1, 8'h02, 1'b1);
    applyStimulus(OP_SHL, 4'h9, 8'h00, 1'b1);

    // Multiply with an ADD request raised mid-flight that must be dropped.
    loadAcc(8'h13);
    applyStimulus(OP_MUL, 4'h7, 8'h15, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge Clock);
      checkOutput("mul Busy",        32'(bus.Busy),     32'd1);
      checkOutput("mul In_ready",    32'(bus.In_ready), 32'd0);
      checkOutput("mul ALUout hold", 32'(bus.ALUout),   32'h13);
      if (i == 1) begin
        bus.In_valid = 1'b1;
        bus.Function = OP_ADD;
        bus.Data     = 4'h1;
      end
      if (i == 2) bus.In_valid = 1'b0;
    end
    @(negedge Clock);
    checkOutput("mul Busy cleared", 32'(bus.Busy),   32'd0);
    checkOutput("mul product",      32'(bus.ALUout), 32'h15);
    checkOutput("mul Done",         32'(bus.Done),   32'd1);
    @(negedge Clock);
    checkOutput("mul Done one cycle", 32'(bus.Done),   32'd0);
    checkOutput("mul ADD ignored",    32'(bus.ALUout), 32'h15);

    // Reset two cycles into a multiply discards the product.
    loadAcc(8'h35);
    applyStimulus(OP_MUL, 4'h9, 8'h2D, 1'b0);
    @(negedge Clock);
    resetDut(1'b1);
    for (int i = 0; i < DATA_W + 1; i++) begin
      @(negedge Clock);
      checkOutput("aborted mul Done",   32'(bus.Done),   32'd0);
      checkOutput("aborted mul ALUout", 32'(bus.ALUout), 32'd0);
      checkOutput("aborted mul Busy",   32'(bus.Busy),   32'd0);
    end
    applyStimulus(OP_HOLD, 4'h3, 8'h00, 1'b0);

    for (int i = 0; i < 24; i++) begin
      modelStimulus(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge Clock);
      n++;
    end
    checkOutput("pending results", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
